pc_ctrl: RTL and testbench
==========================

# pc_ctrl

Parametrised program-counter controller for the basic processor's fetch stage. It has a start/run/halt state machine and increments the PC by default. It supports signed relative branches, absolute jumps, stall, and range-checked trap detection. An optional return-address stack adds call/return. The fetch stage reads `PC` directly as the instruction-memory address; the decoder drives the control inputs.

## Interface
- `PC_W`, default 10: PC width in bits.
- `OFF_W`, default 8: branch offset width; the offset is signed two's complement.
- `START_ADDR`, default 0: PC value loaded on `start`.
- `HALT_ADDR`, default 63: normal halt occurs once PC > `HALT_ADDR`.
- `RAS_DEPTH`, default 4: return-address stack entries (used only with `PC_RAS_EN`).

Ports:
- `CLK` input 1: clock, rising edge.
- `init_n` input 1: asynchronous, active-low reset.
- `start` input 1: synchronous restart pulse.
- `stall` input 1: hold PC this cycle.
- `branch_en` input 1: taken relative branch.
- `branch_off` input `OFF_W`: signed branch offset.
- `jump_en` input 1: absolute jump.
- `call_en` input 1: call, which jumps to `jump_target` and pushes the return address.
- `ret_en` input 1: return, which pops into PC.
- `jump_target` input `PC_W`: absolute target for jump/call.
- `PC` output `PC_W`: current program counter.
- `halt` output 1: high while in HALTED.
- `fault` output 1: high when the halt was caused by a trap.
- `running` output 1: high in RUN.

## Operation
- States are IDLE, RUN and HALTED.
  - IDLE to RUN on `start`.
  - RUN to HALTED on a normal halt or a trap.
  - HALTED to RUN on `start`.
  - `start` in RUN also restarts.
- `start`, in any state:
  - PC <= `START_ADDR`; `fault` <= 0; stack emptied; state <= RUN.
  - `start` has highest priority.
- In IDLE and HALTED, PC holds and all other controls are ignored.
- RUN priority, evaluated each edge:
  1. PC > `HALT_ADDR`: go to HALTED, PC holds, `fault` = 0.
  2. `stall`: PC holds.
  3. `ret_en`.
  4. `call_en`.
  5. `jump_en`.
  6. `branch_en`.
  7. Otherwise PC <= PC+1.
- Simultaneous controls: only the highest-priority one acts; the rest are dropped.
- Jump: PC <= `jump_target`.
- Branch:
  - Target is PC plus sign-extended `branch_off`, computed in `PC_W`+1 signed bits.
  - Target < 0 or > 2^`PC_W`-1 is a trap: go to HALTED, `fault` = 1, PC holds.
  - Otherwise PC <= target.
- Increment wrap: PC = 2^`PC_W`-1 with increment is a trap (no silent wrap to 0).
- Call/return semantics depend on `PC_RAS_EN` (see Configuration).
- Normal halt is evaluated before the stall check, so a stalled PC beyond `HALT_ADDR` still halts.

## Timing
- Reset (`init_n` low, asynchronous): PC = 0, state = IDLE, `halt` = 0, `fault` = 0, `running` = 0, stack empty.
- Deassertion is sampled at the next rising `CLK` edge.
- All outputs are registered. A control sampled at edge N is reflected in `PC`/`halt` after edge N; there is no combinational input-to-output path.
- `halt`, `fault` and `running` are decoded from the state register and change in the same cycle as the state.
- `start` takes effect one edge after it is sampled. The first fetch address `START_ADDR` is valid the cycle after.
- Reset asserted mid-RUN aborts immediately with the reset values above. The stack contents are discarded.

## Configuration
- `PC_RAS_EN` defined: `RAS_DEPTH`-entry LIFO return stack.
  - `call_en` pushes PC+1 and sets PC <= `jump_target`.
  - `ret_en` pops into PC.
  - Call when the stack is full is a trap. Return when the stack is empty is a trap.
  - Call/return together: return wins.
- `PC_RAS_EN` undefined:
  - No stack storage.
  - `call_en` behaves exactly as `jump_en` (no push).
  - `ret_en` is ignored: when it is the highest-priority control it is dropped and PC <= PC+1.
  - Ports remain present.

## Test plan
- Reset release, `start` pulse, no controls: PC runs 0,1,...,64; `halt` rises the cycle after PC=64 is observed; `fault` = 0; PC holds at 64.
- PC=20, `branch_en`, `branch_off`=-14: PC=6 next cycle. PC=5, offset=-14: HALTED, `fault` = 1, PC holds at 5.
- PC=10, `stall` and `jump_en` (target 40) together: PC holds 10. `jump_en` alone next cycle: PC=40.
- With `PC_RAS_EN`, `RAS_DEPTH`=2:
  - Call to 30 at PC=3, then call to 50: PC=50, stack holds {4,31}.
  - Ret: PC=31. Ret: PC=4.
  - Third ret: trap with `fault` = 1.
  - Three nested calls: the third traps.
- Without `PC_RAS_EN`: `call_en` at PC=3 (target 30) gives PC=30; `ret_en` alone at PC=30 gives PC=31.
- `init_n` pulsed low mid-RUN at PC=25 (asynchronous, between edges): PC=0, state IDLE immediately. A later `start` with `START_ADDR`=0 resumes at 0 with `fault` = 0.

Source files
------------

// File: rtl/pc_ctrl_if.sv
// Decoder <-> fetch PC controller bus: control requests in, PC and status out.
interface pc_ctrl_if #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8
);
    logic             start;
    logic             stall;
    logic             branch_en;
    logic [OFF_W-1:0] branch_off;
    logic             jump_en;
    logic             call_en;
    logic             ret_en;
    logic [PC_W-1:0]  jump_target;
    logic [PC_W-1:0]  PC;
    logic             halt;
    logic             fault;
    logic             running;

    modport master (
        output start, stall, branch_en, branch_off, jump_en, call_en, ret_en, jump_target,
        input  PC, halt, fault, running
    );
    modport slave (
        input  start, stall, branch_en, branch_off, jump_en, call_en, ret_en, jump_target,
        output PC, halt, fault, running
    );
endinterface

// File: rtl/pc_ctrl.sv
// Fetch-stage PC controller: IDLE/RUN/HALTED FSM, branch/jump/stall, trap detection.
// Define PC_RAS_EN to add a RAS_DEPTH-entry return-address stack for call/return.
module pc_ctrl #(
    parameter int              PC_W       = 10,
    parameter int              OFF_W      = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int              HALT_ADDR  = 63,
    parameter int              RAS_DEPTH  = 4
) (
    input  logic      CLK,
    input  logic      init_n,
    pc_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    localparam logic [PC_W:0] HALT_LIM = (PC_W+1)'(HALT_ADDR);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, pc_inc;
    logic            fault_q, fault_d;
    logic            inc_req, trap, over_halt;
    logic [PC_W+1:0] off_ext, br_sum;

    if (RAS_DEPTH < 1) begin : g_depth_chk
        $error("RAS_DEPTH must be at least 1");
    end

    assign pc_inc    = pc_q + PC_W'(1);
    assign over_halt = {1'b0, pc_q} > HALT_LIM;
    // Two guard bits: anything landing outside [0, 2^PC_W-1] shows up in the top bits.
    assign off_ext   = (PC_W+2)'($signed(bus.branch_off));
    assign br_sum    = {2'b00, pc_q} + off_ext;

`ifdef PC_RAS_EN
    localparam int SP_W  = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic             push, ras_full;

    assign wr_idx   = IDX_W'(sp_q);
    assign rd_idx   = IDX_W'(sp_q - SP_W'(1));
    assign ras_full = sp_q == SP_W'(RAS_DEPTH);

    // Stack storage has no reset; only the pointer defines what is valid.
    always_ff @(posedge CLK) begin
        if (push) ras_q[wr_idx] <= pc_inc;
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        inc_req = 1'b0;
        trap    = 1'b0;
`ifdef PC_RAS_EN
        sp_d    = sp_q;
        push    = 1'b0;
`endif
        if (bus.start) begin
            state_d = RUN;
            pc_d    = START_ADDR;
            fault_d = 1'b0;
`ifdef PC_RAS_EN
            sp_d    = '0;
`endif
        end else if (state_q == RUN) begin
            if (over_halt) begin
                state_d = HALTED;
                fault_d = 1'b0;
            end else if (bus.stall) begin
                pc_d = pc_q;
            end else if (bus.ret_en) begin
`ifdef PC_RAS_EN
                if (sp_q == '0) trap = 1'b1;
                else begin
                    pc_d = ras_q[rd_idx];
                    sp_d = sp_q - SP_W'(1);
                end
`else
                inc_req = 1'b1;
`endif
            end else if (bus.call_en) begin
`ifdef PC_RAS_EN
                if (ras_full) trap = 1'b1;
                else begin
                    pc_d = bus.jump_target;
                    sp_d = sp_q + SP_W'(1);
                    push = 1'b1;
                end
`else
                pc_d = bus.jump_target;
`endif
            end else if (bus.jump_en) begin
                pc_d = bus.jump_target;
            end else if (bus.branch_en) begin
                if (|br_sum[PC_W+1:PC_W]) trap = 1'b1;
                else pc_d = br_sum[PC_W-1:0];
            end else begin
                inc_req = 1'b1;
            end

            // Incrementing past the top of the address space traps instead of wrapping.
            if (inc_req) begin
                if (&pc_q) trap = 1'b1;
                else pc_d = pc_inc;
            end
            if (trap) begin
                state_d = HALTED;
                fault_d = 1'b1;
                pc_d    = pc_q;
            end
        end
    end

    always_ff @(posedge CLK or negedge init_n) begin
        if (!init_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            fault_q <= 1'b0;
`ifdef PC_RAS_EN
            sp_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
`ifdef PC_RAS_EN
            sp_q    <= sp_d;
`endif
        end
    end

    assign bus.PC      = pc_q;
    assign bus.halt    = state_q == HALTED;
    assign bus.running = state_q == RUN;
    assign bus.fault   = fault_q;
endmodule

// File: tb/tb_pc_ctrl.sv
// Scoreboard bench for pc_ctrl: expected snapshots queued with each stimulus cycle.
module tb_pc_ctrl;
    localparam int PC_W  = 10;
    localparam int OFF_W = 8;
`ifdef PC_RAS_EN
    localparam int RAS_D = 2;
`else
    localparam int RAS_D = 4;
`endif

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            halt;
        logic            fault;
        logic            running;
    } snap_t;

    logic  CLK = 1'b0;
    logic  init_n = 1'b0;
    int    checks = 0;
    int    errors = 0;
    snap_t exp_q[$];
    snap_t obs_q[$];

    pc_ctrl_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bus ();

    pc_ctrl #(
        .PC_W(PC_W), .OFF_W(OFF_W), .START_ADDR(10'd0), .HALT_ADDR(63), .RAS_DEPTH(RAS_D)
    ) dut (
        .CLK(CLK), .init_n(init_n), .bus(bus)
    );

    always #5 CLK = ~CLK;

    task automatic clr();
        bus.start = 0; bus.stall = 0; bus.branch_en = 0; bus.branch_off = '0;
        bus.jump_en = 0; bus.call_en = 0; bus.ret_en = 0; bus.jump_target = '0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
        clr();
    endtask

    task automatic snap_now(input int pc, input logic h, input logic f, input logic r);
        exp_q.push_back(snap_t'{PC_W'(pc), h, f, r});
        obs_q.push_back(snap_t'{bus.PC, bus.halt, bus.fault, bus.running});
    endtask

    task automatic step(input int pc, input logic h, input logic f, input logic r);
        exp_q.push_back(snap_t'{PC_W'(pc), h, f, r});
        tick();
        obs_q.push_back(snap_t'{bus.PC, bus.halt, bus.fault, bus.running});
    endtask

    task automatic go_to(input int n);
        bus.start = 1;
        tick();
        repeat (n) tick();
    endtask

    task automatic test_reset();
        #1 snap_now(0, 0, 0, 0);
        #1 init_n = 1;
        step(0, 0, 0, 0);
        while (exp_q.size() != 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset: got pc=%0d h=%b f=%b r=%b want pc=%0d h=%b f=%b r=%b",
                         o.pc, o.halt, o.fault, o.running, e.pc, e.halt, e.fault, e.running);
            end
        end
    endtask

    task automatic test_run_to_halt();
        bus.start = 1;
        step(0, 0, 0, 1);
        for (int k = 1; k <= 64; k++) step(k, 0, 0, 1);
        step(64, 1, 0, 0);
        step(64, 1, 0, 0);
        bus.jump_en = 1; bus.jump_target = 10'd5;
        step(64, 1, 0, 0);
        while (exp_q.size() != 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL run_halt: got pc=%0d h=%b f=%b r=%b want pc=%0d h=%b f=%b r=%b",
                         o.pc, o.halt, o.fault, o.running, e.pc, e.halt, e.fault, e.running);
            end
        end
    endtask

    task automatic test_branch();
        go_to(20);
        bus.branch_en = 1; bus.branch_off = OFF_W'(-14);
        step(6, 0, 0, 1);
        bus.branch_en = 1; bus.branch_off = OFF_W'(20);
        step(26, 0, 0, 1);
        bus.branch_en = 1; bus.branch_off = OFF_W'(1); bus.jump_en = 1; bus.jump_target = 10'd40;
        step(40, 0, 0, 1);
        go_to(14);
        bus.branch_en = 1; bus.branch_off = OFF_W'(-14);
        step(0, 0, 0, 1);
        go_to(5);
        bus.branch_en = 1; bus.branch_off = OFF_W'(-14);
        step(5, 1, 1, 0);
        step(5, 1, 1, 0);
        bus.start = 1;
        step(0, 0, 0, 1);
        while (exp_q.size() != 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch: got pc=%0d h=%b f=%b r=%b want pc=%0d h=%b f=%b r=%b",
                         o.pc, o.halt, o.fault, o.running, e.pc, e.halt, e.fault, e.running);
            end
        end
    endtask

    task automatic test_stall_jump();
        go_to(10);
        bus.stall = 1; bus.jump_en = 1; bus.jump_target = 10'd40;
        step(10, 0, 0, 1);
        bus.jump_en = 1; bus.jump_target = 10'd40;
        step(40, 0, 0, 1);
        bus.start = 1; bus.jump_en = 1; bus.jump_target = 10'd33;
        step(0, 0, 0, 1);
        bus.jump_en = 1; bus.jump_target = 10'd100;
        step(100, 0, 0, 1);
        bus.stall = 1;
        step(100, 1, 0, 0);
        while (exp_q.size() != 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall_jump: got pc=%0d h=%b f=%b r=%b want pc=%0d h=%b f=%b r=%b",
                         o.pc, o.halt, o.fault, o.running, e.pc, e.halt, e.fault, e.running);
            end
        end
    endtask

    task automatic test_call_ret();
        go_to(3);
`ifdef PC_RAS_EN
        bus.call_en = 1; bus.jump_target = 10'd30;
        step(30, 0, 0, 1);
        bus.call_en = 1; bus.jump_target = 10'd50;
        step(50, 0, 0, 1);
        bus.ret_en = 1;
        step(31, 0, 0, 1);
        bus.ret_en = 1;
        step(4, 0, 0, 1);
        bus.ret_en = 1;
        step(4, 1, 1, 0);
        bus.start = 1;
        step(0, 0, 0, 1);
        bus.call_en = 1; bus.jump_target = 10'd10;
        step(10, 0, 0, 1);
        bus.call_en = 1; bus.jump_target = 10'd20;
        step(20, 0, 0, 1);
        bus.call_en = 1; bus.jump_target = 10'd30;
        step(20, 1, 1, 0);
        bus.start = 1;
        step(0, 0, 0, 1);
        bus.call_en = 1; bus.jump_target = 10'd10;
        step(10, 0, 0, 1);
        bus.call_en = 1; bus.ret_en = 1; bus.jump_target = 10'd40;
        step(1, 0, 0, 1);
        bus.ret_en = 1;
        step(1, 1, 1, 0);
`else
        bus.call_en = 1; bus.jump_target = 10'd30;
        step(30, 0, 0, 1);
        bus.ret_en = 1;
        step(31, 0, 0, 1);
        bus.call_en = 1; bus.ret_en = 1; bus.jump_target = 10'd5;
        step(32, 0, 0, 1);
`endif
        while (exp_q.size() != 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL call_ret: got pc=%0d h=%b f=%b r=%b want pc=%0d h=%b f=%b r=%b",
                         o.pc, o.halt, o.fault, o.running, e.pc, e.halt, e.fault, e.running);
            end
        end
    endtask

    task automatic test_async_reset();
        go_to(3);
        bus.call_en = 1; bus.jump_target = 10'd25;
        step(25, 0, 0, 1);
        #2 init_n = 0;
        #1 snap_now(0, 0, 0, 0);
        init_n = 1;
        step(0, 0, 0, 0);
        bus.start = 1;
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
`ifdef PC_RAS_EN
        bus.ret_en = 1;
        step(1, 1, 1, 0);
`else
        bus.ret_en = 1;
        step(2, 0, 0, 1);
`endif
        while (exp_q.size() != 0) begin
            snap_t e = exp_q.pop_front();
            snap_t o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL async_reset: got pc=%0d h=%b f=%b r=%b want pc=%0d h=%b f=%b r=%b",
                         o.pc, o.halt, o.fault, o.running, e.pc, e.halt, e.fault, e.running);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        test_reset();
        test_run_to_halt();
        test_branch();
        test_stall_jump();
        test_call_ret();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
